// File: rtl/uart_tx_if.sv
// Requester-side bus of the shared UART transmitter: per-requester valid/data,
// one-hot accept pulse, and the index of the most recently accepted requester.
interface uart_tx_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*DATA_BITS-1:0] req_data;
    logic [NUM_REQ-1:0]           req_ready;
    logic [GW-1:0]                grant_id;

    modport master (output req_valid, req_data, input req_ready, grant_id);
    modport slave  (input req_valid, req_data, output req_ready, grant_id);
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler feeding one 8N1 serial line from NUM_REQ byte producers.
// Baud rate selection is only committed while idle so a frame never changes speed.
module uart_tx_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud_tick,
    uart_tx_if.slave   req,
    input  logic [1:0] cfg_baud_sel,
    output logic [1:0] baud_sel,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {IDLE, SYNC, START, DATA, STOP} state_e;

    state_e                 state_q, state_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]          gid_q, gid_d;
    logic [NUM_REQ-1:0]     ready_q, ready_d;
    logic [1:0]             bsel_q, bsel_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   found;
    logic [GW-1:0]          gnt;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req.req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
                found = 1'b1;
                gnt   = GW'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        rr_ptr_d  = rr_ptr_q;
        gid_d     = gid_q;
        bsel_d    = bsel_q;
        tx_d      = tx_q;
        ready_d   = '0;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (found) begin
                    ready_d[gnt] = 1'b1;
                    shreg_d      = req.req_data[int'(gnt)*DATA_BITS +: DATA_BITS];
                    gid_d        = gnt;
                    rr_ptr_d     = (gnt == GW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
                    state_d      = SYNC;
                end else begin
                    bsel_d = cfg_baud_sel;
                end
            end
            // The grant-cycle tick is never seen here, so SYNC always waits for a fresh one.
            SYNC: if (baud_tick) begin
                state_d = START;
                tx_d    = 1'b0;
            end
            START: if (baud_tick) begin
                state_d   = DATA;
                tx_d      = shreg_q[0];
                bit_cnt_d = '0;
            end
            DATA: if (baud_tick) begin
                if (bit_cnt_q == CW'(DATA_BITS - 1)) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end else begin
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    tx_d      = shreg_q[1];
                end
            end
            STOP: if (baud_tick) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            rr_ptr_q  <= '0;
            gid_q     <= '0;
            ready_q   <= '0;
            bsel_q    <= 2'b00;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            rr_ptr_q  <= rr_ptr_d;
            gid_q     <= gid_d;
            ready_q   <= ready_d;
            bsel_q    <= bsel_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign req.req_ready = ready_q;
    assign req.grant_id  = gid_q;
    assign baud_sel      = bsel_q;
    assign tx            = tx_q;
    assign busy          = busy_q;
    assign frame_done    = done_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: a per-requester source driver, a serial-line decoder
// and grant/frame scoreboards fed with expectations when requests are posted.
module tb_uart_tx_scheduler;
    localparam int NR = 4;
    localparam int DB = 8;

    typedef struct { int id; logic [7:0] data; } exp_t;
    typedef struct { int id; logic [7:0] data; int div; logic [1:0] cfg; } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud_tick = 1'b0;
    logic [1:0] cfg_baud_sel = 2'b00;
    logic [1:0] baud_sel;
    logic       tx, busy, frame_done;

    uart_tx_if #(.NUM_REQ(NR), .DATA_BITS(DB)) bus ();

    uart_tx_scheduler #(.NUM_REQ(NR), .DATA_BITS(DB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .baud_tick    (baud_tick),
        .req          (bus),
        .cfg_baud_sel (cfg_baud_sel),
        .baud_sel     (baud_sel),
        .tx           (tx),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expectation queues, pushed by the test when it posts a byte.
    exp_t gq[$];
    exp_t fq[$];

    // Source side: each requester holds valid/data until it sees its ready pulse.
    logic [7:0] src_data [NR][4];
    int         src_n [NR];
    int         src_i [NR];
    int         div = 4;
    int         tcnt = 0;
    logic       tick_en = 1'b0;
    logic       man_tick = 1'b0;
    logic       tick_on_valid = 1'b0;

    initial begin
        for (int i = 0; i < NR; i++) begin
            src_n[i] = 0;
            src_i[i] = 0;
        end
        bus.req_valid = '0;
        bus.req_data  = '0;
    end

    task automatic post(input int id, input logic [7:0] d);
        exp_t e;
        src_data[id][src_n[id]] = d;
        src_n[id]++;
        e.id = id;
        e.data = d;
        gq.push_back(e);
        fq.push_back(e);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (!rst_n) src_i[i] = src_n[i];
            else if (bus.req_ready[i] && src_i[i] < src_n[i]) src_i[i]++;
            bus.req_valid[i] = (src_i[i] < src_n[i]);
            bus.req_data[i*DB +: DB] = (src_i[i] < src_n[i] && src_i[i] < 4) ?
                                       src_data[i][src_i[i]] : 8'($urandom);
        end
        if (tick_en) begin
            if (tcnt >= div - 1) begin
                tcnt = 0;
                baud_tick = 1'b1;
            end else begin
                tcnt++;
                baud_tick = 1'b0;
            end
        end else begin
            baud_tick = man_tick || (tick_on_valid && (|bus.req_valid) && !busy);
        end
    end

    // Grant checker: one-hot ready, in expected order, never while a frame is open.
    int   gi = 0;
    logic frame_open = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            gi = gq.size();
            frame_open = 1'b0;
        end else begin
            if (frame_done) frame_open = 1'b0;
            if (|bus.req_ready) begin
                chk("ready_onehot", 32'($countones(bus.req_ready)), 1);
                chk("ready_after_done", 32'(frame_open), 0);
                if (gi >= gq.size()) chk("unexpected_grant", 0, 1);
                else begin
                    chk("grant_ready", 32'(bus.req_ready), 32'(1) << gq[gi].id);
                    chk("grant_id_now", 32'(bus.grant_id), 32'(gq[gi].id));
                    gi++;
                end
                frame_open = 1'b1;
            end
        end
    end

    // Line decoder: samples tx just after each tick edge and checks it holds between ticks.
    int         fi = 0;
    int         nb = 0;
    logic       in_frame = 1'b0;
    logic       cur = 1'b1;
    logic       tk;
    logic [7:0] acc = '0;
    always @(posedge clk) begin
        tk = baud_tick;
        #1;
        if (!rst_n) begin
            in_frame = 1'b0;
            fi = fq.size();
        end else begin
            if (frame_done && !(in_frame && tk && nb == DB + 1))
                chk("stray_frame_done", 32'(frame_done), 0);
            if (tk && !in_frame) begin
                if (busy && tx == 1'b0) begin
                    in_frame = 1'b1;
                    nb = 0;
                    cur = 1'b0;
                end
            end else if (tk) begin
                if (nb < DB) begin
                    acc[nb] = tx;
                    cur = tx;
                    nb++;
                end else if (nb == DB) begin
                    chk("stop_bit", 32'(tx), 1);
                    cur = tx;
                    nb++;
                end else begin
                    chk("frame_done", 32'(frame_done), 1);
                    if (fi >= fq.size()) chk("unexpected_frame", 0, 1);
                    else begin
                        chk("frame_data", 32'(acc), 32'(fq[fi].data));
                        chk("frame_grant_id", 32'(bus.grant_id), 32'(fq[fi].id));
                        fi++;
                    end
                    in_frame = 1'b0;
                end
            end else if (in_frame) begin
                chk("tx_hold", 32'(tx), 32'(cur));
            end
        end
    end

    task automatic wait_done(input string nm);
        int n = 0;
        while (!(gi == gq.size() && fi == fq.size() && !busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(n < 5000), 1);
    endtask

    task automatic wait_bit(input int k, input string nm);
        int n = 0;
        while (!(in_frame && nb == k) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(n < 5000), 1);
    endtask

    vec_t vt[5];

    initial begin
        vt[0] = '{id: 1, data: 8'hA5, div: 16, cfg: 2'b00};
        vt[1] = '{id: 2, data: 8'h3C, div: 4,  cfg: 2'b01};
        vt[2] = '{id: 0, data: 8'hFF, div: 1,  cfg: 2'b10};
        vt[3] = '{id: 1, data: 8'h81, div: 3,  cfg: 2'b11};
        vt[4] = '{id: 3, data: 8'h00, div: 5,  cfg: 2'b00};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_baud_sel", 32'(baud_sel), 0);
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_grant_id", 32'(bus.grant_id), 0);
        rst_n = 1'b1;
        tick_en = 1'b1;
        repeat (2) @(negedge clk);

        // Single-requester frames; last one from requester 3 wraps rr_ptr to 0
        for (int v = 0; v < 5; v++) begin
            cfg_baud_sel = vt[v].cfg;
            div = vt[v].div;
            post(vt[v].id, vt[v].data);
            wait_done("vec_timeout");
            repeat (3) @(negedge clk);
            chk("vec_baud_sel", 32'(baud_sel), 32'(vt[v].cfg));
        end

        // All requesters held: strict rotation 0,1,2,3,0
        div = 2;
        post(0, 8'h11);
        post(1, 8'h22);
        post(2, 8'h33);
        post(3, 8'h44);
        post(0, 8'h55);
        wait_done("rr_timeout");

        // Rate change mid-frame applies only after frame_done on an idle, request-free cycle
        begin
            int n = 0;
            div = 16;
            post(1, 8'h6E);
            wait_bit(3, "cfg_wait_timeout");
            cfg_baud_sel = 2'b11;
            while (n < 400) begin
                @(negedge clk);
                chk("baud_hold", 32'(baud_sel), 0);
                if (frame_done) break;
                n++;
            end
            chk("cfg_frame_timeout", 32'(n < 400), 1);
            @(negedge clk);
            chk("baud_apply", 32'(baud_sel), 3);
            wait_done("cfg_timeout");
        end

        // Reset during data bit 4, then req0 beats req2 because rr_ptr returns to 0
        div = 8;
        post(1, 8'hC3);
        wait_bit(5, "rst_wait_timeout");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", 32'(tx), 1);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_baud_sel", 32'(baud_sel), 0);
        chk("midrst_grant_id", 32'(bus.grant_id), 0);
        cfg_baud_sel = 2'b00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        post(0, 8'h96);
        post(2, 8'h4B);
        wait_done("postrst_timeout");

        // Tick coincident with the grant is not counted toward SYNC
        begin
            int n = 0;
            tick_en = 1'b0;
            tick_on_valid = 1'b1;
            @(negedge clk);
            #1;
            post(2, 8'h5A);
            while (n < 50) begin
                @(negedge clk);
                #1;
                if (bus.req_ready[2]) break;
                n++;
            end
            chk("coin_grant_timeout", 32'(n < 50), 1);
            tick_on_valid = 1'b0;
            chk("coin_tx_sync", 32'(tx), 1);
            chk("coin_busy", 32'(busy), 1);
            repeat (3) @(negedge clk);
            #1;
            chk("coin_tx_wait", 32'(tx), 1);
            man_tick = 1'b1;
            @(negedge clk);
            #1;
            man_tick = 1'b0;
            @(negedge clk);
            #1;
            chk("coin_start", 32'(tx), 0);
            div = 4;
            tcnt = 0;
            tick_en = 1'b1;
            wait_done("coin_timeout");
        end

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
